ifetch_unit: RTL

- Instruction-fetch front end. Consumes the current PC from the PC register and issues single-word reads on the instruction bus.
- Registers each returned instruction with its address for the decode stage.
- Drives the PC hold flag back to the PC register, so the PC advances only when a fetch is accepted.
- Flushes in-flight and buffered fetches on a jump.

---
 rtl/hidamari_pkg.sv | 14 +
 rtl/ifetch_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/hidamari_pkg.sv
// Shared types and defaults for the hidamari core front end.
package hidamari_pkg;

    localparam int          ADDR_WIDTH_DEF = 32;
    localparam int          DATA_WIDTH_DEF = 32;
    localparam logic [31:0] NOP_INST_DEF   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } ifetch_state_e;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding bus read, instruction valid two cycles after grant.
// Stalls (no request, PC held) while the decode slot is full and not being consumed.
module ifetch_unit
    import hidamari_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = NOP_INST_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  jump_flag_in,
    output logic                  pc_hold_flag_out,
    output logic                  ibus_req_out,
    output logic [ADDR_WIDTH-1:0] ibus_addr_out,
    input  logic                  ibus_gnt_in,
    input  logic                  ibus_rvalid_in,
    input  logic [DATA_WIDTH-1:0] ibus_rdata_in,
    output logic                  inst_valid_out,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_addr_out,
    input  logic                  id_ready_in
);

    ifetch_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  inst_vld_q, inst_vld_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_addr_q, inst_addr_d;
    logic                  slot_free;
    logic                  load;

    assign slot_free = !inst_vld_q || id_ready_in;

    // pc_in is stale during a jump cycle, so no request may go out then.
    assign ibus_req_out     = !rst && (state_q == S_REQ) && !jump_flag_in && slot_free;
    assign ibus_addr_out    = pc_in;
    assign pc_hold_flag_out = !(ibus_req_out && ibus_gnt_in);

    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        load        = 1'b0;
        case (state_q)
            S_REQ: begin
                if (ibus_req_out && ibus_gnt_in) begin
                    state_d     = S_WAIT;
                    pend_addr_d = pc_in;
                end
            end
            S_WAIT: begin
                if (ibus_rvalid_in) begin
                    state_d = S_REQ;
                    load    = !jump_flag_in;
                end else if (jump_flag_in) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (ibus_rvalid_in) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Load wins over consume; a jump squashes whatever the slot holds.
    always_comb begin
        inst_vld_d  = inst_vld_q;
        inst_d      = inst_q;
        inst_addr_d = inst_addr_q;
        if (load) begin
            inst_vld_d  = 1'b1;
            inst_d      = ibus_rdata_in;
            inst_addr_d = pend_addr_q;
        end else if (jump_flag_in || (inst_vld_q && id_ready_in)) begin
            inst_vld_d = 1'b0;
            inst_d     = NOP_INST;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_REQ;
            pend_addr_q <= '0;
            inst_vld_q  <= 1'b0;
            inst_q      <= NOP_INST;
            inst_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            inst_vld_q  <= inst_vld_d;
            inst_q      <= inst_d;
            inst_addr_q <= inst_addr_d;
        end
    end

    assign inst_valid_out = inst_vld_q;
    assign inst_out       = inst_q;
    assign inst_addr_out  = inst_addr_q;

endmodule
